mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I/D cache requesters, the arbiter and the memory port.
// The master modport is the requester/memory side; the arbiter takes the slave modport.
interface mem_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  // Handshake: a requester raises req (level) with write/addr/wdata stable; the arbiter
  // samples them only in the cycle it grants, and answers with a one-cycle done pulse.
  // Memory: read_m/write_m are held with addr/data_out for the whole access; data_in is
  // sampled in the final access cycle.
  logic                 i__req;
  logic                 d__req;
  logic                 i__write;
  logic                 d__write;
  logic [WORD_SIZE-1:0] i__addr;
  logic [WORD_SIZE-1:0] d__addr;
  logic [WORD_SIZE-1:0] i__wdata;
  logic [WORD_SIZE-1:0] d__wdata;
  logic                 i__done;
  logic                 d__done;
  logic [WORD_SIZE-1:0] o__rdata;
  logic                 m__read_m;
  logic                 m__write_m;
  logic [WORD_SIZE-1:0] m__addr;
  logic [WORD_SIZE-1:0] m__data_out;
  logic [WORD_SIZE-1:0] m__data_in;
  logic                 busy;

  modport master (
    output i__req, d__req, i__write, d__write,
    output i__addr, d__addr, i__wdata, d__wdata,
    output m__data_in,
    input  i__done, d__done, o__rdata,
    input  m__read_m, m__write_m, m__addr, m__data_out,
    input  busy
  );

  modport slave (
    input  i__req, d__req, i__write, d__write,
    input  i__addr, d__addr, i__wdata, d__wdata,
    input  m__data_in,
    output i__done, d__done, o__rdata,
    output m__read_m, m__write_m, m__addr, m__data_out,
    output busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter onto a single fixed-latency memory port.
// Define ROUND_ROBIN_EN for alternating tie-break; default build gives the D side fixed priority.
module mem_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 4
) (
  input  logic             clk,
  input  logic             reset,
  mem_arbiter_if.slave     bus,
  output logic [1:0]       o_dbg_state
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE_I = 2'd1;
  localparam logic [1:0] ST_SERVE_D = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [3:0] LAT = MEM_LATENCY[3:0];

  logic [1:0]           r_state;
  logic [3:0]           r_cnt;
  logic                 r_sel_d;
  logic                 r_write;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [WORD_SIZE-1:0] r_rdata;
`ifdef ROUND_ROBIN_EN
  // 1 = D was granted last; reset value 0 lets D win the first tie.
  logic                 r_last_d;
`endif

  logic                 w_grant_any;
  logic                 w_grant_d;
  logic                 w_serving;

  always_comb begin
    w_grant_any = bus.i__req || bus.d__req;
`ifdef ROUND_ROBIN_EN
    w_grant_d   = bus.d__req && (!bus.i__req || !r_last_d);
`else
    w_grant_d   = bus.d__req;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_sel_d  <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
`ifdef ROUND_ROBIN_EN
      r_last_d <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_any) begin
            r_sel_d  <= w_grant_d;
            r_write  <= w_grant_d ? bus.d__write : bus.i__write;
            r_addr   <= w_grant_d ? bus.d__addr  : bus.i__addr;
            r_wdata  <= w_grant_d ? bus.d__wdata : bus.i__wdata;
            r_cnt    <= LAT;
            r_state  <= w_grant_d ? ST_SERVE_D : ST_SERVE_I;
`ifdef ROUND_ROBIN_EN
            r_last_d <= w_grant_d;
`endif
          end
        end
        ST_SERVE_I, ST_SERVE_D: begin
          // Memory data is only guaranteed valid in the final access cycle.
          if (r_cnt == 4'd1) begin
            if (!r_write) begin
              r_rdata <= bus.m__data_in;
            end
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_serving = (r_state == ST_SERVE_I) || (r_state == ST_SERVE_D);

  assign bus.m__read_m   = w_serving && !r_write;
  assign bus.m__write_m  = w_serving &&  r_write;
  assign bus.m__addr     = r_addr;
  assign bus.m__data_out = r_wdata;
  assign bus.i__done     = (r_state == ST_DONE) && !r_sel_d;
  assign bus.d__done     = (r_state == ST_DONE) &&  r_sel_d;
  assign bus.o__rdata    = r_rdata;
  assign bus.busy        = (r_state != ST_IDLE);
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: single accesses, ties, request drop and reset.
module tb_mem_arbiter;

  localparam int WORD_SIZE   = 16;
  localparam int MEM_LATENCY = 4;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [0:0] exp_q[$];
  logic       exp_d;
  int         done_seen_n;

  mem_arbiter_if #(.WORD_SIZE(WORD_SIZE)) bus ();

  mem_arbiter #(
    .WORD_SIZE   (WORD_SIZE),
    .MEM_LATENCY (MEM_LATENCY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // driver tasks
  task automatic drive_idle();
    bus.i__req    = 1'b0;
    bus.d__req    = 1'b0;
    bus.i__write  = 1'b0;
    bus.d__write  = 1'b0;
    bus.i__addr   = '0;
    bus.d__addr   = '0;
    bus.i__wdata  = '0;
    bus.d__wdata  = '0;
    bus.m__data_in = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_state"}, dbg_state, 2'd0);
    check_eq({tag, "_outs"},
             {bus.busy, bus.i__done, bus.d__done, bus.m__read_m, bus.m__write_m}, 5'b0);
    check_eq({tag, "_maddr"}, bus.m__addr, 16'h0);
    check_eq({tag, "_mdata"}, bus.m__data_out, 16'h0);
    check_eq({tag, "_rdata"}, bus.o__rdata, 16'h0);
  endtask

  // Called at the falling edge of the first serve cycle; returns at the following IDLE cycle.
  task automatic observe_txn(input logic exp_sel_d, input logic exp_wr,
                             input logic [15:0] exp_addr, input logic [15:0] exp_wdata,
                             input logic [15:0] exp_rdata);
    int   cyc      = 0;
    int   strobe_n = 0;
    logic seen     = 1'b0;
    logic bad_bus  = 1'b0;
    logic wrong_st = 1'b0;
    while (!seen && cyc < 32) begin
      if (bus.i__done || bus.d__done) begin
        seen = 1'b1;
        check_eq("done_latency", cyc, MEM_LATENCY);
        check_eq("done_who", {bus.i__done, bus.d__done}, exp_sel_d ? 2'b01 : 2'b10);
        check_eq("rdata", bus.o__rdata, exp_rdata);
        check_eq("done_state_busy", {dbg_state, bus.busy}, {2'd3, 1'b1});
        check_eq("strobe_in_done", {bus.m__read_m, bus.m__write_m}, 2'b00);
      end else begin
        if (exp_wr ? bus.m__write_m : bus.m__read_m) begin
          strobe_n++;
          if (bus.m__addr !== exp_addr) bad_bus = 1'b1;
          if (exp_wr && bus.m__data_out !== exp_wdata) bad_bus = 1'b1;
        end
        if (exp_wr ? bus.m__read_m : bus.m__write_m) wrong_st = 1'b1;
        cyc++;
        @(negedge clk);
      end
    end
    check_eq("done_seen", seen, 1'b1);
    check_eq("strobe_cycles", strobe_n, MEM_LATENCY);
    check_eq("strobe_addr_data", bad_bus, 1'b0);
    check_eq("other_strobe", wrong_st, 1'b0);
    @(negedge clk);
    check_eq("done_one_cycle", {bus.i__done, bus.d__done}, 2'b00);
    check_eq("idle_busy", bus.busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_all_zero("reset");

    // I read with req held for a single cycle only
    bus.i__req     = 1'b1;
    bus.i__write   = 1'b0;
    bus.i__addr    = 16'h0010;
    bus.m__data_in = 16'hBEEF;
    @(negedge clk);
    bus.i__req     = 1'b0;
    bus.i__addr    = 16'hFFFF;
    observe_txn(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);

    // D write; read-data register must keep the previous captured word
    bus.d__req     = 1'b1;
    bus.d__write   = 1'b1;
    bus.d__addr    = 16'h0020;
    bus.d__wdata   = 16'h1234;
    bus.m__data_in = 16'h5555;
    @(negedge clk);
    bus.d__req     = 1'b0;
    observe_txn(1'b1, 1'b1, 16'h0020, 16'h1234, 16'hBEEF);

    // Reset during the second SERVE_D cycle aborts without a done pulse
    bus.d__req     = 1'b1;
    bus.d__write   = 1'b0;
    bus.d__addr    = 16'h0030;
    @(negedge clk);
    bus.d__req     = 1'b0;
    check_eq("serve_d_state", dbg_state, 2'd2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("midop_reset");
    done_seen_n = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.i__done || bus.d__done) done_seen_n++;
    end
    check_eq("no_done_after_abort", done_seen_n, 0);

    // Reset beats a request arriving in IDLE
    bus.d__req = 1'b1;
    reset      = 1'b1;
    @(negedge clk);
    bus.d__req = 1'b0;
    reset      = 1'b0;
    check_eq("reset_prio_state", dbg_state, 2'd0);
    check_eq("reset_prio_busy", bus.busy, 1'b0);

    // Tie with both requests held: grant order comes from the expected queue
    do_reset();
`ifdef ROUND_ROBIN_EN
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
`else
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
`endif
    bus.i__req     = 1'b1;
    bus.d__req     = 1'b1;
    bus.i__write   = 1'b0;
    bus.d__write   = 1'b0;
    bus.i__addr    = 16'h0040;
    bus.d__addr    = 16'h0050;
    bus.m__data_in = 16'hA5A5;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_d = exp_q.pop_front();
      observe_txn(exp_d, 1'b0, exp_d ? 16'h0050 : 16'h0040, 16'h0000, 16'hA5A5);
      if (exp_q.size() == 0) begin
        bus.i__req = 1'b0;
        bus.d__req = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    repeat (3) @(negedge clk);
    check_eq("tie_end_idle", dbg_state, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
